// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// The producer/consumer side uses master; the subtractor itself uses slave.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one full-adder cell (b inverted) per clock,
// LSB first, with valid/ready on both the operand and the result side.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_subtractor_if.slave bus,
    output logic               busy
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   diff_q;
    logic [CNT_W-1:0]   cnt;
    logic               br;
    logic               borrow_q;
    logic               ovf_q;
    logic               in_ready;
    logic               out_valid;
    logic               a_bit;
    logic               b_bit;
    logic               d_bit;
    logic               br_nxt;
    logic               last_bit;

    // Borrow-chain cell: equivalent to a full adder fed with ~b and an inverted carry.
    assign a_bit    = a_sh[0];
    assign b_bit    = b_sh[0];
    assign d_bit    = a_bit ^ b_bit ^ br;
    assign br_nxt   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // diff_q doubles as the result shift register; it is only meaningful in DONE
    // and otherwise holds whatever was last shifted in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            diff_q   <= '0;
            cnt      <= '0;
            br       <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh <= bus.a;
                        b_sh <= bus.b;
                        br   <= 1'b0;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    diff_q <= {d_bit, diff_q[WIDTH-1:1]};
                    br     <= br_nxt;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // On the last bit a_bit/b_bit are the operand sign bits.
                        borrow_q <= br_nxt;
                        ovf_q    <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for serial_subtractor (WIDTH=8 and WIDTH=4 instances).
`timescale 1ns/1ps
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n;
    logic busy8;
    logic busy4;
    int   n_tests = 0;
    int   n_fail  = 0;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(4)) bus4 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus8.slave),
        .busy (busy8)
    );

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus4.slave),
        .busy (busy4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one operand pair to the 8-bit DUT (assumed idle), swaps the operand
    // bus to a_late/b_late after acceptance, and counts cycles until out_valid.
    task automatic run8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] a_late, input logic [7:0] b_late,
                        output int lat);
        bus8.a        = a;
        bus8.b        = b;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.a        = a_late;
        bus8.b        = b_late;
        lat = 0;
        while (!bus8.out_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic pop8();
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_tests++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || busy8 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     bus8.in_ready, bus8.out_valid, busy8);
        end
        n_tests++;
        if (bus8.diff !== 8'h00 || bus8.borrow !== 1'b0 || bus8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_data got diff=%h borrow=%b ovf=%b want 00 0 0",
                     bus8.diff, bus8.borrow, bus8.ovf);
        end
        n_tests++;
        if (bus4.in_ready !== 1'b1 || bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl4 got in_ready=%b out_valid=%b busy=%b want 1 0 0",
                     bus4.in_ready, bus4.out_valid, busy4);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        run8(8'd5, 8'd3, 8'd5, 8'd3, lat);
        n_tests++;
        if (lat !== 8) begin
            n_fail++;
            $display("FAIL basic_latency got %0d want 8", lat);
        end
        n_tests++;
        if (bus8.diff !== 8'h02 || bus8.borrow !== 1'b0 || bus8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result got diff=%h borrow=%b ovf=%b want 02 0 0",
                     bus8.diff, bus8.borrow, bus8.ovf);
        end
        n_tests++;
        if (bus8.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_in_ready_done got %b want 0", bus8.in_ready);
        end
        pop8();
        n_tests++;
        if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pop got in_ready=%b out_valid=%b want 1 0",
                     bus8.in_ready, bus8.out_valid);
        end
    endtask

    task automatic test_boundaries();
        logic [7:0] va [4];
        logic [7:0] vb [4];
        logic [7:0] vd [4];
        logic       vbr[4];
        logic       vov[4];
        int         lat;
        va[0] = 8'h00; vb[0] = 8'h01; vd[0] = 8'hFF; vbr[0] = 1'b1; vov[0] = 1'b0;
        va[1] = 8'h80; vb[1] = 8'h01; vd[1] = 8'h7F; vbr[1] = 1'b0; vov[1] = 1'b1;
        va[2] = 8'h5A; vb[2] = 8'h5A; vd[2] = 8'h00; vbr[2] = 1'b0; vov[2] = 1'b0;
        va[3] = 8'h7F; vb[3] = 8'hFF; vd[3] = 8'h80; vbr[3] = 1'b1; vov[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run8(va[i], vb[i], va[i], vb[i], lat);
            n_tests++;
            if (lat !== 8 || bus8.diff !== vd[i] || bus8.borrow !== vbr[i] || bus8.ovf !== vov[i]) begin
                n_fail++;
                $display("FAIL boundary_%0d a=%h b=%h got lat=%0d diff=%h borrow=%b ovf=%b want 8 %h %b %b",
                         i, va[i], vb[i], lat, bus8.diff, bus8.borrow, bus8.ovf, vd[i], vbr[i], vov[i]);
            end
            pop8();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        run8(8'h30, 8'h10, 8'h30, 8'h10, lat);
        for (int i = 0; i < 5; i++) begin
            bus8.in_valid = 1'b1;
            bus8.a        = 8'd1;
            bus8.b        = 8'd1;
            tick();
            n_tests++;
            if (bus8.out_valid !== 1'b1 || bus8.in_ready !== 1'b0 || bus8.diff !== 8'h20 ||
                bus8.borrow !== 1'b0 || bus8.ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure_hold_%0d got out_valid=%b in_ready=%b diff=%h borrow=%b ovf=%b want 1 0 20 0 0",
                         i, bus8.out_valid, bus8.in_ready, bus8.diff, bus8.borrow, bus8.ovf);
            end
        end
        bus8.in_valid = 1'b0;
        pop8();
        n_tests++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || busy8 !== 1'b0 || bus8.diff !== 8'h20) begin
            n_fail++;
            $display("FAIL backpressure_release got out_valid=%b in_ready=%b busy=%b diff=%h want 0 1 0 20",
                     bus8.out_valid, bus8.in_ready, busy8, bus8.diff);
        end
    endtask

    task automatic test_operand_change();
        int lat;
        run8(8'd9, 8'd4, 8'hFF, 8'h00, lat);
        n_tests++;
        if (lat !== 8 || bus8.diff !== 8'd5 || bus8.borrow !== 1'b0) begin
            n_fail++;
            $display("FAIL operand_change got lat=%0d diff=%h borrow=%b want 8 05 0",
                     lat, bus8.diff, bus8.borrow);
        end
        pop8();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        bus8.a        = 8'hF0;
        bus8.b        = 8'h0F;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        n_tests++;
        if (busy8 !== 1'b1 || bus8.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_busy got busy=%b out_valid=%b want 1 0", busy8, bus8.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus8.out_valid !== 1'b0 || busy8 !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.diff !== 8'h00) begin
            n_fail++;
            $display("FAIL midrun_abort got out_valid=%b busy=%b in_ready=%b diff=%h want 0 0 1 00",
                     bus8.out_valid, busy8, bus8.in_ready, bus8.diff);
        end
        tick();
        rst_n = 1'b1;
        tick();
        run8(8'd20, 8'd7, 8'd20, 8'd7, lat);
        n_tests++;
        if (lat !== 8 || bus8.diff !== 8'd13 || bus8.borrow !== 1'b0 || bus8.ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_recover got lat=%0d diff=%h borrow=%b ovf=%b want 8 0d 0 0",
                     lat, bus8.diff, bus8.borrow, bus8.ovf);
        end
        pop8();
    endtask

    task automatic test_exhaustive4();
        int sent = 0;
        int got  = 0;
        fork
            begin : producer
                for (int i = 0; i < 256; i++) begin
                    int   wait_c;
                    logic rdy;
                    bus4.a        = 4'(i >> 4);
                    bus4.b        = 4'(i & 15);
                    bus4.in_valid = 1'b1;
                    wait_c = 0;
                    rdy    = 1'b0;
                    while (!rdy && wait_c < 200) begin
                        rdy = bus4.in_ready;
                        tick();
                        wait_c++;
                    end
                    if (!rdy) break;
                    sent++;
                end
                bus4.in_valid = 1'b0;
            end
            begin : consumer
                int c;
                c = 0;
                while (got < 256 && c < 20000) begin
                    logic       v;
                    logic       r;
                    logic [3:0] d;
                    logic       bo;
                    logic       ov;
                    bus4.out_ready = 1'($urandom_range(0, 1));
                    v  = bus4.out_valid;
                    r  = bus4.out_ready;
                    d  = bus4.diff;
                    bo = bus4.borrow;
                    ov = bus4.ovf;
                    tick();
                    c++;
                    if (v && r) begin
                        int         ea, eb, sa, sb, sd;
                        logic [3:0] ed;
                        logic       ebr, eov;
                        ea  = got >> 4;
                        eb  = got & 15;
                        ed  = 4'(ea - eb);
                        ebr = (ea < eb);
                        sa  = (ea > 7) ? ea - 16 : ea;
                        sb  = (eb > 7) ? eb - 16 : eb;
                        sd  = sa - sb;
                        eov = (sd > 7) || (sd < -8);
                        n_tests++;
                        if (d !== ed || bo !== ebr || ov !== eov) begin
                            n_fail++;
                            $display("FAIL exh4 a=%0d b=%0d got diff=%h borrow=%b ovf=%b want %h %b %b",
                                     ea, eb, d, bo, ov, ed, ebr, eov);
                        end
                        got++;
                    end
                end
                bus4.out_ready = 1'b0;
            end
        join
        n_tests++;
        if (sent !== 256 || got !== 256) begin
            n_fail++;
            $display("FAIL exh4_count got sent=%0d received=%0d want 256 256", sent, got);
        end
        tick();
        tick();
        n_tests++;
        if (bus4.out_valid !== 1'b0 || busy4 !== 1'b0) begin
            n_fail++;
            $display("FAIL exh4_drain got out_valid=%b busy=%b want 0 0", bus4.out_valid, busy4);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus4.in_valid  = 1'b0;
        bus4.out_ready = 1'b0;
        bus4.a         = '0;
        bus4.b         = '0;
        test_reset();
        test_basic();
        test_boundaries();
        test_backpressure();
        test_operand_change();
        test_reset_mid_run();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor computing diff = a - b, one bit per clock, LSB first.
- Inverse companion to the team's ripple adder: uses the same full-adder bit cell with b inverted, processed serially instead of in parallel.
- Sits between an operand producer and a result consumer. Both sides use a valid/ready handshake.
- Trades WIDTH cycles of latency for a single-bit datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous assert, active-low
- in_valid  input  1  operands a, b valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow  output  1  1 iff unsigned a < b
- ovf  output  1  signed overflow of a - b
- busy  output  1  state != IDLE

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low; it is the only reset.
- Reset values (immediately on rst_n low, held while low):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - diff=0, borrow=0, ovf=0.
  - Bit counter=0, internal borrow=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a and b into shift registers, clear the internal borrow, counter=0, go to RUN.
  - Operands are sampled only at this acceptance edge; later changes on a/b are ignored.
- RUN:
  - in_ready=0.
  - Each edge processes bit i = counter:
    - d = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
  - d shifts into the result register from the MSB side.
  - After bit WIDTH-1, go to DONE.
- DONE:
  - out_valid=1; in_ready=0.
  - diff, borrow and ovf are stable.
  - Stays in DONE while out_ready=0.
  - On an edge with out_ready=1, go to IDLE.
- Latency:
  - Acceptance at edge T; bits are processed at edges T+1..T+WIDTH.
  - out_valid rises after edge T+WIDTH.
  - Minimum issue interval is WIDTH+2 cycles: out_valid and in_ready are never high in the same cycle.
- Outputs:
  - borrow = final internal borrow.
  - ovf = (a[WIDTH-1] ^ b[WIDTH-1]) & (a[WIDTH-1] ^ diff[WIDTH-1]), using the latched operands.
  - diff, borrow and ovf are registered.
  - They keep the last result after returning to IDLE, until the next result overwrites them.
  - They are don't-care whenever out_valid=0.
- Wrap-around: arithmetic is modulo 2^WIDTH; there is no saturation.
- in_valid while busy is ignored; no queueing.
- Reset mid-operation:
  - Asserting rst_n in RUN or DONE aborts immediately; the in-flight result is lost.
  - All outputs return to their reset values, and out_valid must not glitch high.
- After rst_n deassertion, the first in_valid edge is accepted normally.
- Equal operands: diff=0, borrow=0, ovf=0.

Test Plan:
- Basic subtract, WIDTH=8: a=8'd5, b=8'd3, in_valid for 1 cycle -> out_valid exactly 8 cycles after acceptance; diff=8'h02, borrow=0, ovf=0.
- Unsigned underflow: a=8'h00, b=8'h01 -> diff=8'hFF, borrow=1, ovf=0. Also a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> diff, borrow and ovf stable; in_ready=0 throughout; a new in_valid with a=1, b=1 is ignored. Then out_ready=1 -> IDLE the next cycle, in_ready=1.
- Operand change after accept: a=8'd9, b=8'd4 accepted, then drive a=8'hFF, b=8'h00 during RUN -> result diff=8'd5.
- Reset mid-RUN: assert rst_n=0 after 3 RUN cycles -> out_valid=0, busy=0, in_ready=1 immediately. After release, a=8'd20, b=8'd7 yields diff=8'd13 with normal latency.
- Exhaustive, WIDTH=4: all 256 (a,b) pairs back-to-back with random out_ready stalls -> diff=(a-b)&4'hF, borrow=(a<b), and ovf matches the signed reference for every pair; no result lost or duplicated.
